// File: rtl/cmem_pkg.sv
// cmem_pkg: shared types and default sizes for the banked coefficient memory
package cmem_pkg;
  typedef enum logic {IDLE, STREAM} cmem_state_t;
  localparam int CMEM_DATA_W = 16;
  localparam int CMEM_DEPTH = 64;
endpackage

// File: rtl/cmem_banked_if.sv
// cmem_banked_if: host/stream bus of cmem_banked; readback port present under CMEM_READBACK_EN
interface cmem_banked_if
  import cmem_pkg::*;
#(
  parameter int DATA_W = CMEM_DATA_W,
  parameter int DEPTH = CMEM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] data_in;
  logic swap_req;
  logic swap_pending;
  logic swap_done;
  logic active_bank;
  logic stream_start;
  logic busy;
  logic [DATA_W-1:0] coef_out;
  logic coef_valid;
  logic coef_last;
`ifdef CMEM_READBACK_EN
  logic rb_bank;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] rb_data;
`endif
  modport master (
    output w_en, w_addr, data_in, swap_req, stream_start,
`ifdef CMEM_READBACK_EN
    output rb_bank, rb_addr,
    input rb_data,
`endif
    input swap_pending, swap_done, active_bank, busy, coef_out, coef_valid, coef_last
  );
  modport slave (
    input w_en, w_addr, data_in, swap_req, stream_start,
`ifdef CMEM_READBACK_EN
    input rb_bank, rb_addr,
    output rb_data,
`endif
    output swap_pending, swap_done, active_bank, busy, coef_out, coef_valid, coef_last
  );
endinterface

// File: rtl/cmem_bank.sv
// cmem_bank: one DEPTH x DATA_W bank, sync write, registered read (second read port under CMEM_READBACK_EN)
module cmem_bank
  import cmem_pkg::*;
#(
  parameter int DATA_W = CMEM_DATA_W,
  parameter int DEPTH = CMEM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
`ifdef CMEM_READBACK_EN
  ,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data
`endif
);
  logic [DATA_W-1:0] mem [DEPTH];
  // storage is never reset; contents are undefined until written
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  // stream read register
  always_ff @(posedge clk) rdata <= rst ? '0 : mem[raddr];
`ifdef CMEM_READBACK_EN
  // host readback register, independent of the stream port
  always_ff @(posedge clk) rb_data <= rst ? '0 : mem[rb_addr];
`endif
endmodule

// File: rtl/cmem_banked.sv
// cmem_banked: double-buffered coefficient memory with deferred swap; optional readback via CMEM_READBACK_EN
module cmem_banked
  import cmem_pkg::*;
#(
  parameter int DATA_W = CMEM_DATA_W,
  parameter int DEPTH = CMEM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  cmem_banked_if.slave bus
);
  cmem_state_t state, state_nx;
  logic [ADDR_W-1:0] ptr, rd_addr;
  logic active, pending, done, valid, last, issue, do_swap;
  logic [DATA_W-1:0] rd [2];
`ifdef CMEM_READBACK_EN
  logic [DATA_W-1:0] rb [2];
  logic rb_sel;
`endif
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // next state: a pass ends on the edge after its last beat was issued
  always_comb state_nx = state == IDLE ? (bus.stream_start ? STREAM : IDLE) : (last ? IDLE : STREAM);
  // FSM outputs: read address, beat issue and swap permission
  always_comb begin
    bus.busy = state == STREAM;
    rd_addr = state == IDLE ? '0 : ptr;
    issue = state == IDLE ? bus.stream_start : !last;
    do_swap = state == IDLE && pending;
  end
  // beat pointer and beat flags, aligned with the registered bank read
  always_ff @(posedge clk)
    if (rst) begin
      ptr <= '0;
      valid <= 1'b0;
      last <= 1'b0;
    end else begin
      ptr <= issue ? rd_addr + ADDR_W'(1) : ptr;
      valid <= issue;
      last <= issue && rd_addr == ADDR_W'(DEPTH - 1);
    end
  // swap bookkeeping: a new request during the executing edge re-arms pending
  always_ff @(posedge clk)
    if (rst) begin
      active <= 1'b0;
      pending <= 1'b0;
      done <= 1'b0;
    end else begin
      active <= active ^ do_swap;
      pending <= bus.swap_req | (pending & ~do_swap);
      done <= do_swap;
    end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    cmem_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank (
      .clk(clk),
      .rst(rst),
      .we(bus.w_en && active != 1'(b)),
      .waddr(bus.w_addr),
      .wdata(bus.data_in),
      .raddr(rd_addr),
      .rdata(rd[b])
`ifdef CMEM_READBACK_EN
      ,
      .rb_addr(bus.rb_addr),
      .rb_data(rb[b])
`endif
    );
  end
`ifdef CMEM_READBACK_EN
  // remember which bank the readback targeted for the 1-cycle-late mux
  always_ff @(posedge clk) rb_sel <= rst ? 1'b0 : bus.rb_bank;
  assign bus.rb_data = rb_sel ? rb[1] : rb[0];
`endif
  // both banks read the same address, and the active bank cannot change mid-pass
  assign bus.coef_out = valid ? rd[active] : '0;
  assign bus.coef_valid = valid;
  assign bus.coef_last = last;
  assign bus.active_bank = active;
  assign bus.swap_pending = pending;
  assign bus.swap_done = done;
endmodule

// File: tb/tb_cmem_banked.sv
// tb_cmem_banked: directed bench with a per-cycle behavioural model of cmem_banked
module tb_cmem_banked;
  localparam int DW = 16;
  localparam int D = 64;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc, done_cyc;
  logic prev_busy = 1'b0;
  logic [DW-1:0] bank_m [2][D];
  int pos = -1;
  bit act = 0, pend = 0, done = 0;
  logic [DW-1:0] cap [$];
  int last_cnt;
  logic [DW-1:0] last_val;

  cmem_banked_if #(.DATA_W(DW), .DEPTH(D)) bus ();
  cmem_banked #(.DATA_W(DW), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_step();
    bit idle;
    if (bus.w_en) bank_m[!act][bus.w_addr] = bus.data_in;
    if (rst) begin
      pos = -1;
      act = 0;
      pend = 0;
      done = 0;
      return;
    end
    idle = pos < 0;
    if (!idle) begin
      pos++;
      if (pos == D) pos = -1;
    end
    done = idle && pend;
    if (done) act = !act;
    pend = bus.swap_req || (pend && !done);
    if (idle && bus.stream_start) pos = 0;
  endtask

  task automatic compare();
    chk("busy", bus.busy, pos >= 0);
    chk("valid", bus.coef_valid, pos >= 0);
    chk("last", bus.coef_last, pos == D - 1);
    chk("active", bus.active_bank, act);
    chk("pending", bus.swap_pending, pend);
    chk("done", bus.swap_done, done);
    if (pos >= 0) chk("coef", bus.coef_out, bank_m[act][pos]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    compare();
    if (bus.coef_valid) cap.push_back(bus.coef_out);
    if (bus.coef_last) begin
      last_cnt++;
      last_val = bus.coef_out;
    end
    if (prev_busy && !bus.busy) fall_cyc = cyc;
    if (bus.swap_done) done_cyc = cyc;
    prev_busy = bus.busy;
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic clear_cap();
    cap.delete();
    last_cnt = 0;
    last_val = '0;
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < D; i++) bank_m[b][i] = '0;
    rst = 1'b1;
    bus.w_en = 1'b0;
    bus.w_addr = '0;
    bus.data_in = '0;
    bus.swap_req = 1'b0;
    bus.stream_start = 1'b0;
`ifdef CMEM_READBACK_EN
    bus.rb_bank = 1'b0;
    bus.rb_addr = '0;
`endif
    run(2);
    chk("rst_coef", bus.coef_out, 0);
    rst = 1'b0;
    // fill shadow bank 1, swap it in, stream it
    for (int i = 0; i < D; i++) begin
      bus.w_en = 1'b1;
      bus.w_addr = 6'(i);
      bus.data_in = 16'h1000 + 16'(i);
      tick();
    end
    bus.w_en = 1'b0;
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    tick();
    chk("t1_active", bus.active_bank, 1);
    clear_cap();
    bus.stream_start = 1'b1;
    tick();
    bus.stream_start = 1'b0;
    run(66);
    chk("t1_len", cap.size(), 64);
    chk("t1_first", cap[0], 16'h1000);
    chk("t1_lastbeat", cap[63], 16'h103F);
    chk("t1_lastcnt", last_cnt, 1);
    chk("t1_lastval", last_val, 16'h103F);
    chk("t1_busy_end", bus.busy, 0);
    // stream bank 1 while rewriting the shadow bank
    clear_cap();
    bus.stream_start = 1'b1;
    for (int i = 0; i < D; i++) begin
      bus.w_en = 1'b1;
      bus.w_addr = 6'(i);
      bus.data_in = 16'h2000 + 16'(i);
      tick();
      bus.stream_start = 1'b0;
    end
    bus.w_en = 1'b0;
    run(3);
    chk("t2_old_first", cap[0], 16'h1000);
    chk("t2_old_last", cap[63], 16'h103F);
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    tick();
    clear_cap();
    bus.stream_start = 1'b1;
    tick();
    bus.stream_start = 1'b0;
    run(66);
    chk("t2_new_first", cap[0], 16'h2000);
    chk("t2_new_last", cap[63], 16'h203F);
    // swap request mid-pass is deferred until the stream goes idle
    clear_cap();
    fall_cyc = -1;
    done_cyc = -1;
    bus.stream_start = 1'b1;
    tick();
    bus.stream_start = 1'b0;
    run(9);
    bus.swap_req = 1'b1;
`ifdef CMEM_READBACK_EN
    bus.rb_bank = 1'b0;
    bus.rb_addr = 6'd7;
`endif
    tick();
    bus.swap_req = 1'b0;
`ifdef CMEM_READBACK_EN
    chk("rb_data", bus.rb_data, 16'h2007);
`endif
    chk("t3_pend_mid", bus.swap_pending, 1);
    run(60);
    chk("t3_len", cap.size(), 64);
    chk("t3_beat10", cap[10], 16'h200A);
    chk("t3_done_gap", done_cyc - fall_cyc, 1);
    chk("t3_active", bus.active_bank, 1);
    // swap executes on the same edge the stream starts
    clear_cap();
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    bus.stream_start = 1'b1;
    tick();
    bus.stream_start = 1'b0;
    chk("t4_active", bus.active_bank, 0);
    chk("t4_beat0", bus.coef_out, 16'h2000);
    run(66);
    chk("t4_last", cap[63], 16'h203F);
    // stream_start during a pass is ignored
    clear_cap();
    bus.stream_start = 1'b1;
    tick();
    bus.stream_start = 1'b0;
    run(4);
    bus.stream_start = 1'b1;
    tick();
    bus.stream_start = 1'b0;
    run(66);
    chk("t5_len", cap.size(), 64);
    // reset mid-pass aborts and drops a pending swap
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    tick();
    bus.stream_start = 1'b1;
    tick();
    bus.stream_start = 1'b0;
    run(2);
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    run(16);
    chk("t5_pre_active", bus.active_bank, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", bus.busy, 0);
    chk("t5_valid", bus.coef_valid, 0);
    chk("t5_last", bus.coef_last, 0);
    chk("t5_coef", bus.coef_out, 0);
    chk("t5_active", bus.active_bank, 0);
    chk("t5_pend", bus.swap_pending, 0);
    chk("t5_done", bus.swap_done, 0);
    run(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cmem_banked.md
# cmem_banked

Parametrised, double-buffered coefficient memory for the FIR datapath. It holds two banks of DEPTH × DATA_W coefficients. The host writes the shadow bank while the filter streams the active bank one coefficient per cycle. A host swap request is deferred until the stream is idle, so a coefficient set is never changed partway through a filter pass.

## Interface
- DATA_W, 16, coefficient width in bits
- DEPTH, 64, coefficients per bank (≥2)
- ADDR_W, $clog2(DEPTH), address width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- w_en  in  1  write strobe; targets the shadow bank
- w_addr  in  ADDR_W  write address
- data_in  in  DATA_W  write data
- swap_req  in  1  request a swap of the active and shadow banks (1-cycle pulse)
- swap_pending  out  1  swap requested, not yet performed
- swap_done  out  1  1-cycle pulse after the edge that performs a swap
- active_bank  out  1  index of the bank being streamed
- stream_start  in  1  start a pass over addresses 0..DEPTH-1
- busy  out  1  stream in progress
- coef_out  out  DATA_W  streamed coefficient
- coef_valid  out  1  coef_out is valid
- coef_last  out  1  marks address DEPTH-1

## Operation
- Memory contents are not reset; they are undefined until written.
- Writes go to bank ~active_bank, sampled at the edge. A write at the same edge as a swap lands in the pre-swap shadow bank, which becomes the new active bank.
- The streaming FSM in package type cmem_state_t has two states, IDLE and STREAM.
  - IDLE → STREAM: at an edge with stream_start=1 and busy=0. Address 0 is read at that edge and the pointer loads 1.
  - STREAM → IDLE: after the beat for address DEPTH-1 has been issued.
  - stream_start is ignored while busy=1. The minimum gap between passes is one idle cycle.
- Swap handling:
  - swap_req sets swap_pending. A swap_req while swap_pending=1 is absorbed, so one swap results.
  - A swap executes at the first edge where the FSM is IDLE and swap_pending=1. That edge toggles active_bank, clears swap_pending and sets swap_done for one cycle.
  - Swap and stream_start at the same IDLE edge: both are taken. The stream reads the newly active bank.
  - swap_req at the same edge a swap executes: the swap executes and swap_pending stays 1 for a second swap.
- Arithmetic: the pointer counts 0..DEPTH-1 and does not wrap within a pass. A non-power-of-2 DEPTH is legal; addresses ≥DEPTH are never issued.
- Reset values: active_bank=0, busy=0, coef_valid=0, coef_last=0, coef_out=0, swap_pending=0, swap_done=0, FSM=IDLE.
- Reset mid-stream aborts the pass. A pending swap is discarded.

## Timing
- Read latency is 1 cycle. If stream_start is accepted at edge E, then after edge E+k (k=0..DEPTH-1) coef_out=bank[k] and coef_valid=1.
- coef_last=1 only after E+DEPTH-1.
- After E+DEPTH, coef_valid=0 and busy=0.
- busy is high for exactly DEPTH cycles, aligned with coef_valid.
- A write to the active bank is impossible, so the streamed data never depends on concurrent writes.
- swap_done is high the cycle after the swap edge. active_bank changes at the same edge.

## Configuration
- CMEM_READBACK_EN:
  - Defined: adds a host readback port.
    - rb_bank in 1
    - rb_addr in ADDR_W
    - rb_data out DATA_W
    - Reads either bank with 1-cycle latency, independent of the stream.
    - rb_data resets to 0.
    - Each bank is a 1-write/2-read memory.
  - Undefined: the ports are absent and each bank is 1-write/1-read.

## Structure
- Package cmem_pkg holds:
  - cmem_state_t (IDLE, STREAM)
  - the default DATA_W and DEPTH constants
- Sub-module cmem_bank is one DEPTH × DATA_W memory with synchronous write and registered read (a second read port under CMEM_READBACK_EN). It is instantiated twice.
- The FSM, swap logic and output mux live in cmem_banked.

## Test plan
- Reset; write 16'h1000+i to addr i (i=0..63); pulse swap_req; stream_start → active_bank=1, 64 beats 16'h1000..16'h103F, coef_last only on 16'h103F, then busy=0.
- Start a pass on bank 1 while writing 16'h2000+i to every address → pass still yields 16'h1000+i. After swap and restart → 16'h2000+i.
- swap_req at beat 10 of a pass → swap_pending=1 through the pass. swap_done pulses the cycle after busy falls. Beats are unchanged.
- While idle, assert swap_req, then assert stream_start at the same edge the swap executes → the stream reads the new bank from beat 0.
- Pulse stream_start at beat 5 → ignored, pass length stays 64. Assert rst at beat 20 → next cycle all outputs are 0, active_bank=0, swap_pending=0.
- With CMEM_READBACK_EN: rb_bank=0, rb_addr=6'd7 during streaming → rb_data=bank0[7] one cycle later. coef_out is unaffected.
